// File: rtl/ru_sb_pkg.sv
// Shared constants and types for the integer register unit with scoreboard.
package ru_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]          reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/ru_sb_scoreboard.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback
// or flush clears it; also provides busy lookup per read port and a
// registered count of pending registers.
module ru_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREAD*AW-1:0]   i_rs_addr,
    output logic [NREAD-1:0]      o_rs_busy,
    input  logic [NWRITE-1:0]     i_wr_en,
    input  logic [NWRITE*AW-1:0]  i_wr_addr,
    input  logic                  i_issue_en,
    input  logic [AW-1:0]         i_issue_rd,
    input  logic                  i_flush,
    output logic [AW:0]           o_pending_cnt
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      r_pending_cnt;
    logic [AW:0]      w_cnt_nxt;

    // Busy next state: flush, then writeback clears, then issue sets (issue wins).
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        for (int k = 0; k < NWRITE; k++) begin
            if (i_wr_en[k]) begin
                w_busy_nxt[i_wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (i_issue_en) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    // Population count of the next busy vector so the count tracks the bits.
    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
        end
    end

    // Busy vector and pending count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy        <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_pending_cnt <= w_cnt_nxt;
        end
    end

    // Busy lookup per read port; a same-cycle writeback lets the consumer go.
    always_comb begin
        o_rs_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            o_rs_busy[i] = r_busy[i_rs_addr[i*AW +: AW]];
            for (int k = 0; k < NWRITE; k++) begin
                if (i_wr_en[k] && (i_wr_addr[k*AW +: AW] == i_rs_addr[i*AW +: AW])) begin
                    o_rs_busy[i] = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (i_rs_addr[i*AW +: AW] == '0)) begin
                o_rs_busy[i] = 1'b0;
            end
        end
    end

    assign o_pending_cnt = r_pending_cnt;

endmodule

// File: rtl/ru_sb.sv
// Parametrised register unit: multi-port storage with write-first bypass,
// optional hardwired zero register and a busy scoreboard for hazard checks.
module ru_sb
    import ru_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*AW-1:0]     rs_addr,
    output logic [NREAD*XLEN-1:0]   rs_data,
    output logic [NREAD-1:0]        rs_busy,
    input  logic [NWRITE-1:0]       wr_en,
    input  logic [NWRITE*AW-1:0]    wr_addr,
    input  logic [NWRITE*XLEN-1:0]  wr_data,
    input  logic                    issue_en,
    input  logic [AW-1:0]           issue_rd,
    input  logic                    flush,
    output logic [AW:0]             pending_cnt
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Register storage; later write ports override earlier ones on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en[k] && !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0))) begin
                    r_regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Read muxes: storage, overridden by same-cycle writes, zero register last.
    always_comb begin
        rs_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            rs_data[i*XLEN +: XLEN] = r_regs[rs_addr[i*AW +: AW]];
            for (int k = 0; k < NWRITE; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == rs_addr[i*AW +: AW])) begin
                    rs_data[i*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
                end
            end
            if ((ZERO_REG != 0) && (rs_addr[i*AW +: AW] == '0)) begin
                rs_data[i*XLEN +: XLEN] = '0;
            end
        end
    end

    ru_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .NWRITE   (NWRITE),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rs_addr     (rs_addr),
        .o_rs_busy     (rs_busy),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_issue_en    (issue_en),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .o_pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_ru_sb.sv
// Directed bench for ru_sb: a 32x32 dual-write instance and a 16x64
// three-read instance sharing clock and reset.
module tb_ru_sb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main instance (XLEN 32, NREGS 32, NREAD 2, NWRITE 2) ----------------
    logic [9:0]  rs_addr;
    logic [63:0] rs_data;
    logic [1:0]  rs_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [5:0]  pending_cnt;

    ru_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
        .issue_rd(issue_rd), .flush(flush), .pending_cnt(pending_cnt)
    );

    // ---------------- sweep instance (XLEN 64, NREGS 16, NREAD 3, NWRITE 1) ----------------
    logic [11:0]  rs_addr_b;
    logic [191:0] rs_data_b;
    logic [2:0]   rs_busy_b;
    logic [0:0]   wr_en_b;
    logic [3:0]   wr_addr_b;
    logic [63:0]  wr_data_b;
    logic         issue_en_b;
    logic [3:0]   issue_rd_b;
    logic         flush_b;
    logic [4:0]   pending_b;

    ru_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .NWRITE(1), .ZERO_REG(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr_b), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .issue_en(issue_en_b),
        .issue_rd(issue_rd_b), .flush(flush_b), .pending_cnt(pending_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [63:0] got);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expected queue empty, got %h", tag, got);
        end else begin
            e = exp_q.pop_front();
            check(tag, got, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
        wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0;
        issue_en_b = 1'b0; issue_rd_b = '0; flush_b = 1'b0;
    endtask

    task automatic drv_wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wr_en[port] = 1'b1;
        wr_addr[port*5 +: 5] = a;
        wr_data[port*32 +: 32] = d;
    endtask

    task automatic drv_issue(input logic [4:0] rd);
        issue_en = 1'b1;
        issue_rd = rd;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rs_addr = {a1, a0};
    endtask

    task automatic drv_wr_b(input logic [3:0] a, input logic [63:0] d);
        wr_en_b = 1'b1;
        wr_addr_b = a;
        wr_data_b = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        rs_addr = '0;
        rs_addr_b = '0;
        idle();
        #2;
        check("reset_pending", 64'(pending_cnt), 64'd0);
        check("reset_busy", 64'(rs_busy), 64'd0);
        check("reset_pending_b", 64'(pending_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write 5 and issue 12, then reset mid-cycle.
        drv_wr(0, 5'd5, 32'hDEADBEEF);
        drv_issue(5'd12);
        tick();
        idle();
        set_rd(5'd5, 5'd12);
        #1;
        check("pre_reset_rd5", 64'(rs_data[31:0]), 64'hDEADBEEF);
        check("pre_reset_busy12", 64'(rs_busy[1]), 64'd1);
        check("pre_reset_pending", 64'(pending_cnt), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_rd5", 64'(rs_data[31:0]), 64'd0);
        check("async_reset_pending", 64'(pending_cnt), 64'd0);
        check("async_reset_busy12", 64'(rs_busy[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write then read; zero register.
        drv_wr(0, 5'd7, 32'h12345678);
        exp_q.push_back(64'h12345678);
        tick();
        idle();
        set_rd(5'd7, 5'd0);
        #1;
        check_q("rd7_after_write", 64'(rs_data[31:0]));
        drv_wr(0, 5'd0, 32'hFFFFFFFF);
        #1;
        check("rd0_same_cycle_write", 64'(rs_data[63:32]), 64'd0);
        tick();
        idle();
        #1;
        check("rd0_after_write", 64'(rs_data[63:32]), 64'd0);

        // Single-port bypass.
        drv_wr(0, 5'd3, 32'hA5A5A5A5);
        set_rd(5'd3, 5'd7);
        #1;
        check("bypass_rd3", 64'(rs_data[31:0]), 64'hA5A5A5A5);
        check("no_bypass_rd7", 64'(rs_data[63:32]), 64'h12345678);
        tick();
        idle();

        // Dual-port collision: port 1 wins for both bypass and storage.
        drv_wr(0, 5'd3, 32'h1);
        drv_wr(1, 5'd3, 32'h2);
        exp_q.push_back(64'h2);
        set_rd(5'd3, 5'd3);
        #1;
        check("dual_bypass_rd3", 64'(rs_data[31:0]), 64'h2);
        tick();
        idle();
        #1;
        check_q("dual_stored_rd3", 64'(rs_data[63:32]));

        // Scoreboard: issue 9, then writeback 9.
        drv_issue(5'd9);
        tick();
        idle();
        set_rd(5'd9, 5'd0);
        #1;
        check("busy9_after_issue", 64'(rs_busy[0]), 64'd1);
        check("pending_after_issue", 64'(pending_cnt), 64'd1);
        drv_wr(0, 5'd9, 32'h99);
        #1;
        check("busy9_bypass_clear", 64'(rs_busy[0]), 64'd0);
        check("pending_before_wb_edge", 64'(pending_cnt), 64'd1);
        tick();
        idle();
        #1;
        check("busy9_after_wb", 64'(rs_busy[0]), 64'd0);
        check("pending_after_wb", 64'(pending_cnt), 64'd0);

        // Issue and writeback of 4 in the same cycle leaves 4 busy.
        drv_issue(5'd4);
        drv_wr(0, 5'd4, 32'h44);
        tick();
        idle();
        set_rd(5'd4, 5'd0);
        #1;
        check("busy4_issue_and_wb", 64'(rs_busy[0]), 64'd1);
        check("pending_issue_and_wb", 64'(pending_cnt), 64'd1);

        // Issue to register 0 never marks it busy.
        drv_issue(5'd0);
        tick();
        idle();
        #1;
        check("busy0_never", 64'(rs_busy[1]), 64'd0);
        check("pending_issue0", 64'(pending_cnt), 64'd1);

        // Build 2, 4, 8 busy, then flush with issue 6.
        drv_issue(5'd2);
        tick();
        drv_issue(5'd8);
        tick();
        idle();
        set_rd(5'd2, 5'd8);
        #1;
        check("pending_three", 64'(pending_cnt), 64'd3);
        check("busy2_8", 64'(rs_busy), 64'b11);
        flush = 1'b1;
        drv_issue(5'd6);
        tick();
        idle();
        set_rd(5'd6, 5'd4);
        #1;
        check("pending_after_flush", 64'(pending_cnt), 64'd1);
        check("busy6_after_flush", 64'(rs_busy[0]), 64'd1);
        check("busy4_after_flush", 64'(rs_busy[1]), 64'd0);

        // Parameter sweep instance.
        drv_wr_b(4'd5, 64'hFFFF_FFFF_0000_0001);
        tick();
        drv_wr_b(4'd10, 64'h0123_4567_89AB_CDEF);
        tick();
        drv_wr_b(4'd0, 64'h5555_5555_5555_5555);
        tick();
        idle();
        rs_addr_b = {4'd0, 4'd10, 4'd5};
        #1;
        check("b_port0_rd5", rs_data_b[63:0], 64'hFFFF_FFFF_0000_0001);
        check("b_port1_rd10", rs_data_b[127:64], 64'h0123_4567_89AB_CDEF);
        check("b_port2_rd0", rs_data_b[191:128], 64'd0);
        rs_addr_b = {4'd5, 4'd5, 4'd10};
        #1;
        check("b_port0_rd10", rs_data_b[63:0], 64'h0123_4567_89AB_CDEF);
        check("b_port1_rd5", rs_data_b[127:64], 64'hFFFF_FFFF_0000_0001);
        check("b_port2_rd5", rs_data_b[191:128], 64'hFFFF_FFFF_0000_0001);
        check("b_busy_idle", 64'(rs_busy_b), 64'd0);
        check("b_pending_idle", 64'(pending_b), 64'd0);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
